// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard character buffer.
package kbd_pkg;
  localparam int KBD_DEPTH = 16;
  localparam int KBD_PTR_W = 4;
  localparam logic [7:0] ASCII_NUL = 8'h00;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous signals into the clk domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/kbd_char_fifo.sv
// Keyboard character buffer: synchronises PS/2 characters into clk and queues
// them in a first-word-fall-through FIFO popped by the CPU.
module kbd_char_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = KBD_DEPTH,
  parameter int PTR_W = KBD_PTR_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     key_data,
  input  logic           key_valid,
  input  logic           rd_en,
  input  logic           clr_ovf,
  output logic [7:0]     rd_data,
  output logic           empty,
  output logic           full,
  output logic [PTR_W:0] count,
  output logic           ovf
);
  logic           kv_s;
  logic           kv_d;
  logic [7:0]     data_s;
  logic           wr_req;
  logic           char_ok;
  logic           do_rd;
  logic           wr_ok;
  logic           drop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0] count_next;
  logic [7:0]     mem [DEPTH];

  sync_2ff #(.WIDTH(1)) u_sync_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_valid),
    .q     (kv_s)
  );

  // Data travels through the same depth as the strobe, so it is settled when wr_req fires.
  sync_2ff #(.WIDTH(8)) u_sync_data (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_data),
    .q     (data_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kv_d <= 1'b0;
    else        kv_d <= kv_s;
  end

  assign wr_req  = kv_s & ~kv_d;
  assign char_ok = wr_req && (data_s != ASCII_NUL);
  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign wr_ok   = char_ok & (~full | do_rd);
  assign drop    = char_ok & full & ~do_rd;

  always_comb begin
    count_next = count;
    case ({wr_ok, do_rd})
      2'b10:   count_next = count + (PTR_W+1)'(1);
      2'b01:   count_next = count - (PTR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_s;
  end

  assign rd_data = empty ? ASCII_NUL : mem[rd_ptr];
endmodule

// File: tb/tb_kbd_char_fifo.sv
// Directed and randomized checks of kbd_char_fifo against a queue-based model.
module tb_kbd_char_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       key_valid = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       ovf;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic       m_ovf = 1'b0;

  kbd_char_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_data  (key_data),
    .key_valid (key_valid),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] exp_rd;
    exp_rd = (q.size() != 0) ? q[0] : 8'h00;
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
    $display("txn %-10s count=%0d rd_data=%02h ovf=%0b", tag, count, rd_data, ovf);
  endtask

  // One character through the PS/2 path; pop/clr are driven in the write cycle.
  task automatic key(input logic [7:0] ch, input bit pop, input bit clr, input string tag);
    @(negedge clk);
    key_data = ch;
    repeat (3) @(negedge clk);
    key_valid = 1'b1;
    repeat (2) @(negedge clk);
    rd_en = pop;
    clr_ovf = clr;
    @(negedge clk);
    rd_en = 1'b0;
    clr_ovf = 1'b0;
    if (pop && q.size() != 0) void'(q.pop_front());
    if (clr) m_ovf = 1'b0;
    if (ch != 8'h00) begin
      if (q.size() < DEPTH) q.push_back(ch);
      else m_ovf = 1'b1;
    end
    check_state(tag);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pop(input string tag);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_state(tag);
  endtask

  task automatic clear_ovf(input string tag);
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    m_ovf = 1'b0;
    check_state(tag);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_state("post_rst");

    // Single character, then pop back to empty
    key(8'h41, 0, 0, "single");
    pop("single_pop");

    // NUL is discarded
    key(8'h00, 0, 0, "nul");

    // Fill, overflow, ordered drain, clear flag
    for (int i = 0; i < 16; i++) key(8'h30 + 8'(i), 0, 0, "fill");
    key(8'h5A, 0, 0, "ovf");
    for (int i = 0; i < 16; i++) pop("drain");
    clear_ovf("clr");

    // Full FIFO with pop coinciding with the write
    for (int i = 0; i < 16; i++) key(8'h60 + 8'(i), 0, 0, "fill2");
    key(8'h58, 1, 0, "simul");
    for (int i = 0; i < 16; i++) pop("drain2");

    // Drop in the same cycle as clr_ovf: drop wins
    for (int i = 0; i < 16; i++) key(8'h70 + 8'(i), 0, 0, "fill3");
    key(8'h7E, 0, 1, "drop_clr");
    clear_ovf("clr2");
    for (int i = 0; i < 16; i++) pop("drain3");

    // Randomized interleaving of writes and pops wraps the pointers
    for (int i = 0; i < 40; i++) begin
      key(8'($urandom_range(1, 255)), ($urandom_range(0, 3) == 0), 0, "rnd_wr");
      if ($urandom_range(0, 2) != 0) pop("rnd_pop");
    end
    while (q.size() != 0) pop("rnd_drain");

    // Pop while empty changes nothing
    pop("empty_rd");

    // Asynchronous reset mid-run
    for (int i = 0; i < 3; i++) key(8'h21 + 8'(i), 0, 0, "pre_rst");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    key(8'h42, 0, 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
